// File: rtl/spm_seq_ctrl.sv
// Sequencing controller for a serial-parallel multiplier (spm) datapath.
// Feeds the multiplier LSB first, flushes the array and gathers the 2*WIDTH-bit product.
module spm_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int P_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_x,
   input  logic [WIDTH-1:0]     in_y,
   output logic                 spm_clr,
   output logic [WIDTH-1:0]     spm_x,
   output logic                 spm_y,
   input  logic                 spm_p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic                 busy
);

   // Input side:  a transfer happens on an edge where in_valid && in_ready.
   // Output side: a transfer happens on an edge where out_valid && out_ready;
   //              out_valid/out_p stay stable until that edge.

   localparam int RUN_LEN = 2 * WIDTH + P_LAT;
   localparam int CW      = $clog2(RUN_LEN + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(RUN_LEN - 1);
   localparam logic [CW-1:0] CNT_FEED = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_CAP  = CW'(P_LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  y_sh;
   logic              accept;
   logic              feed;
   logic              capture;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = CLEAR;
         CLEAR:   state_next = RUN;
         RUN:     if (cnt == CNT_LAST) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Every control output is forced to its reset value while rst is high,
   // so nothing observable depends on the pre-reset state.
   always_comb begin
      in_ready  = 1'b0;
      spm_clr   = rst;
      spm_y     = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      feed      = 1'b0;
      capture   = 1'b0;
      if (!rst) begin
         busy = (state != IDLE);
         case (state)
            IDLE:  in_ready = 1'b1;
            CLEAR: spm_clr  = 1'b1;
            RUN: begin
               feed    = (cnt < CNT_FEED);
               capture = (cnt >= CNT_CAP);
               spm_y   = feed & y_sh[0];
            end
            DONE:  out_valid = 1'b1;
            default: ;
         endcase
      end
   end

   // Product bits emerge LSB first P_LAT cycles after their y bit; shifting
   // them in at the MSB leaves the first one at out_p[0] after 2*WIDTH captures.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         y_sh  <= '0;
         out_p <= '0;
         spm_x <= '0;
      end else begin
         if (accept) begin
            spm_x <= in_x;
            y_sh  <= in_y;
         end
         if (state == CLEAR) begin
            cnt <= '0;
         end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
         end
         if (feed) begin
            y_sh <= y_sh >> 1;
         end
         if (capture) begin
            out_p <= {spm_p, out_p[2*WIDTH-1:1]};
         end
      end
   end

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Bench for spm_seq_ctrl (WIDTH=4, P_LAT=1) driving a behavioural serial-parallel
// multiplier; products are scoreboarded against in_x*in_y.
module tb_spm_seq_ctrl;

   localparam int W  = 4;
   localparam int PL = 1;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_x = '0;
   logic [W-1:0]  in_y = '0;
   logic          in_ready;
   logic          spm_clr;
   logic [W-1:0]  spm_x;
   logic          spm_y;
   logic          spm_p;
   logic          out_valid;
   logic [PW-1:0] out_p;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int accepts = 0;
   int clr_pulses = 0;
   int n_issued = 0;
   logic [PW-1:0] exp_q[$];
   logic [W-1:0]  x_lat = '0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   spm_seq_ctrl #(.WIDTH(W), .P_LAT(PL)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .spm_clr   (spm_clr),
      .spm_x     (spm_x),
      .spm_y     (spm_y),
      .spm_p     (spm_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .busy      (busy)
   );

   // Gold spm datapath: one registered product bit per y bit (latency 1).
   logic [W-1:0] acc;
   logic         p_reg;
   logic [W:0]   sum;
   always @(posedge clk) begin
      sum = {1'b0, acc} + (spm_y ? {1'b0, spm_x} : '0);
      if (spm_clr) begin
         acc   <= '0;
         p_reg <= 1'b0;
      end else begin
         p_reg <= sum[0];
         acc   <= sum[W:1];
      end
   end
   assign spm_p = p_reg;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic          prev_hold = 1'b0;
   logic [PW-1:0] held_p = '0;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_hold = 1'b0;
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_busy", busy, 0);
         chk("rst_spm_clr", spm_clr, 1);
         chk("rst_spm_y", spm_y, 0);
      end else begin
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_p", out_p, held_p);
         end
         if (spm_clr) clr_pulses++;
         if (busy) chk("spm_x_stable", spm_x, x_lat);
         if (in_valid && in_ready) begin
            accepts++;
            x_lat = in_x;
            exp_q.push_back(PW'(in_x) * PW'(in_y));
         end
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 0);
               else chk("product", out_p, exp_q.pop_front());
            end
            prev_hold = !out_ready;
            held_p    = out_p;
         end else begin
            prev_hold = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
      int k;
      in_valid = 1'b1;
      in_x = x;
      in_y = y;
      k = 0;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      chk("accept_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      n_issued++;
   endtask

   task automatic wait_valid(output int lat);
      int k;
      k = 0;
      while (!out_valid && k < 100) begin
         tick();
         k++;
      end
      lat = k;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat;
      int gap;
      logic [W-1:0] tx[3];
      logic [W-1:0] ty[3];
      logic [PW-1:0] te[3];
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      int k;
      logic done;

      rst = 1'b1;
      repeat (3) tick();
      chk("reset_in_ready", in_ready, 0);
      chk("reset_busy", busy, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_spm_clr", spm_clr, 1);
      chk("reset_spm_y", spm_y, 0);
      chk("reset_out_p", out_p, 0);
      chk("reset_spm_x", spm_x, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_spm_clr", spm_clr, 0);
      chk("post_rst_busy", busy, 0);

      // 5 x 3 with latency and busy release
      out_ready = 1'b1;
      issue(4'd5, 4'd3);
      chk("clear_cycle_spm_clr", spm_clr, 1);
      chk("clear_cycle_spm_y", spm_y, 0);
      wait_valid(lat);
      chk("latency_5x3", lat, 2 * W + PL + 1);
      chk("p_5x3", out_p, 15);
      tick();
      chk("busy_after_5x3", busy, 0);
      chk("valid_after_5x3", out_valid, 0);

      // corner operands
      tx = '{4'd15, 4'd0, 4'd9};
      ty = '{4'd15, 4'd9, 4'd0};
      te = '{8'd225, 8'd0, 8'd0};
      for (int i = 0; i < 3; i++) begin
         issue(tx[i], ty[i]);
         wait_valid(lat);
         chk("latency_corner", lat, 2 * W + PL + 1);
         chk("p_corner", out_p, te[i]);
         tick();
      end

      // backpressure for six cycles in DONE
      out_ready = 1'b0;
      issue(4'd13, 4'd11);
      wait_valid(lat);
      chk("p_13x11", out_p, 143);
      repeat (6) begin
         tick();
         chk("stall_valid", out_valid, 1);
         chk("stall_p", out_p, 143);
      end
      out_ready = 1'b1;
      tick();
      chk("stall_release_valid", out_valid, 0);
      chk("stall_release_busy", busy, 0);
      chk("stall_release_in_ready", in_ready, 1);

      // reset at RUN cnt=3 abandons the operation
      issue(4'd3, 4'd5);
      repeat (4) tick();
      chk("busy_mid_run", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      repeat (2 * W + PL + 4) begin
         tick();
         chk("abort_no_valid", out_valid, 0);
      end
      issue(4'd7, 4'd6);
      wait_valid(lat);
      chk("p_7x6", out_p, 42);
      tick();

      // three back-to-back pairs with in_valid held high
      tx = '{4'd11, 4'd6, 4'd14};
      ty = '{4'd13, 4'd10, 4'd3};
      in_valid = 1'b1;
      gap = 0;
      for (int i = 0; i < 3; i++) begin
         in_x = tx[i];
         in_y = ty[i];
         if (i > 0) chk("b2b_ready_low_cycles", gap, 2 * W + PL + 2);
         chk("b2b_accept_ready", in_ready, 1);
         tick();
         n_issued++;
         gap = 0;
         if (i < 2) begin
            while (!in_ready && gap < 100) begin
               tick();
               gap++;
            end
         end
      end
      in_valid = 1'b0;
      wait_valid(lat);
      chk("b2b_last_valid", out_valid, 1);
      tick();

      // random operands with random consumer stalls
      for (int n = 0; n < 1000; n++) begin
         rx = W'($urandom_range(0, 15));
         ry = W'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) tick();
         issue(rx, ry);
         k = 0;
         done = 1'b0;
         while (!done && k < 300) begin
            out_ready = ($urandom_range(0, 3) != 0);
            done = out_valid && out_ready;
            tick();
            k++;
         end
         if (!done) chk("random_drain_timeout", out_valid, 1);
      end

      out_ready = 1'b1;
      repeat (3) tick();
      chk("queue_empty", exp_q.size(), 0);
      chk("accept_count", accepts, n_issued);
      chk("clr_once_per_op", clr_pulses, accepts);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spm_seq_ctrl.md
SPM_SEQ_CTRL -- requirements
Module: spm_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand width; matches the spm datapath width.
REQ-002 Parameter P_LAT, default 1: cycles from driving a spm_y bit to the matching spm_p bit.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  controller accepts operands; transfer occurs when in_valid and in_ready are both high.
REQ-007 in_x  input  WIDTH  multiplicand (parallel operand).
REQ-008 in_y  input  WIDTH  multiplier (serial operand).
REQ-009 spm_clr  output  1  clear to the spm datapath (partial sums and carries).
REQ-010 spm_x  output  WIDTH  parallel operand to the spm datapath.
REQ-011 spm_y  output  1  serial operand bit to the spm datapath.
REQ-012 spm_p  input  1  serial product bit from the spm datapath.
REQ-013 out_valid  output  1  product available.
REQ-014 out_ready  input  1  consumer accepts product.
REQ-015 out_p  output  2*WIDTH  unsigned product.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, CLEAR, RUN, DONE; one state per cycle; the FSM is the only sequencing element.
REQ-018 IDLE: in_ready=1 (except while rst=1); on transfer, latch in_x into spm_x and in_y into the y shift register, then go to CLEAR.
REQ-019 CLEAR: spm_clr=1 and spm_y=0 for exactly one cycle; cnt<=0; next state RUN.
REQ-020 RUN: lasts exactly 2*WIDTH+P_LAT cycles, cnt = 0 .. 2*WIDTH+P_LAT-1.
REQ-021 RUN, cnt<WIDTH: spm_y = y_sh[0]; y_sh shifts right one bit per cycle (LSB first).
REQ-022 RUN, cnt>=WIDTH: spm_y=0, which flushes the array.
REQ-023 RUN, cnt>=P_LAT: at each edge, spm_p shifts into out_p at the MSB and out_p shifts right; after 2*WIDTH captures, the first captured bit sits at out_p[0].
REQ-024 Counter width: $clog2(2*WIDTH+P_LAT+1) bits, no wrap; at the last cnt, next state is DONE.
REQ-025 DONE: out_valid=1; out_p held stable; on out_ready=1, go to IDLE with out_valid low the next cycle.
REQ-026 out_valid and out_p remain stable under backpressure for any duration.
REQ-027 in_ready=0 in CLEAR, RUN and DONE.
- No operand overlap.
- An in_valid raised during DONE is accepted no earlier than the first IDLE cycle.
REQ-028 Latency: out_valid rises 2*WIDTH+P_LAT+1 edges after the accepting edge.
- Minimum initiation interval: 2*WIDTH+P_LAT+2 cycles.
REQ-029 spm_x holds the latched multiplicand from accept until the next accept; it is never changed mid-operation.
REQ-030 spm_clr = rst OR (state==CLEAR); it is 0 in all other cycles.
REQ-031 Product arithmetic is unsigned: out_p = in_x * in_y, exact, 2*WIDTH bits, no truncation.
REQ-032 in_valid while in_ready=0 has no effect; the offered operands are not sampled.

Reset
REQ-033 While rst=1 at an edge:
- state<=IDLE, cnt<=0, y_sh<=0, out_p<=0, spm_x<=0;
- out_valid=0, busy=0, in_ready=0, spm_y=0, spm_clr=1.
REQ-034 Reset in any state, including mid-RUN or DONE, abandons the operation.
- No out_valid pulse is produced for the abandoned operation.
- in_ready=1 in the first cycle after rst falls.
REQ-035 No output depends on uninitialised state after the first reset edge.

Verification (WIDTH=4, P_LAT=1, bench uses the gold spm datapath)
REQ-036 x=5, y=3, out_ready=1 -> out_valid rises 10 edges after accept; out_p=15; busy low one cycle later.
REQ-037 x=15, y=15 -> out_p=225; x=0, y=9 -> out_p=0; x=9, y=0 -> out_p=0.
REQ-038 out_ready=0 for 6 cycles in DONE -> out_valid stays 1 and out_p stays constant; out_ready=1 -> IDLE next cycle.
REQ-039 rst=1 for one cycle at RUN cnt=3 -> no out_valid; next cycle in_ready=1; new op x=7, y=6 -> out_p=42.
REQ-040 in_valid held high with 3 back-to-back operand pairs -> accepts are spaced exactly 11 cycles apart; products match.
REQ-041 Randomised run of 1000 operand pairs with random out_ready stalls -> every out_p equals in_x*in_y and spm_clr pulses exactly once per operation.
